seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width in bits (32 or 64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  an operation is presented on alu_control/src_a/src_b.
REQ-005 SHALL have port in_ready  output  1  the block can accept an operation this cycle.
REQ-006 SHALL have port alu_control  input  4  operation code from the ALU decoder: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
REQ-007 SHALL have port src_a  input  XLEN  first operand; shift value for shifts.
REQ-008 SHALL have port src_b  input  XLEN  second operand; low log2(XLEN) bits are the shift amount for shifts.
REQ-009 SHALL have port flush  input  1  abandons any in-flight or pending operation.
REQ-010 SHALL have port out_valid  output  1  result/zero hold a completed operation.
REQ-011 SHALL have port out_ready  input  1  the consumer accepts the result this cycle.
REQ-012 SHALL have port result  output  XLEN  operation result.
REQ-013 SHALL have port zero  output  1  high when result equals 0.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-015 SHALL accept an operation when in_valid and in_ready are both high, capturing alu_control, src_a and src_b into internal registers.
REQ-016 Non-shift ops SHALL compute in the capture cycle and enter DONE next cycle (latency 1).
REQ-017 ADD/SUB SHALL wrap modulo 2^XLEN; SLT = signed src_a < src_b, SLTU = unsigned, both giving 1 or 0 zero-extended.
REQ-018 Shift ops with shamt 0 SHALL go IDLE -> DONE with result = src_a (latency 1).
REQ-019 Shift ops with shamt N > 0 SHALL go IDLE -> SHIFT, shift the working register by exactly one bit per cycle, and enter DONE after N SHIFT cycles (latency N+1).
REQ-020 SRA SHALL replicate the captured sign bit on every step; SRL and SLL SHALL fill zeros.
REQ-021 Undefined codes 10-15 SHALL complete with latency 1 and result 0, zero=1.
REQ-022 In DONE, result and zero SHALL remain stable until out_ready is high; the handshake cycle SHALL return the FSM to IDLE.
REQ-023 No new operation SHALL be accepted in the same cycle as the DONE handshake (in_ready low in DONE).
REQ-024 flush SHALL, in any state, return the FSM to IDLE next cycle with out_valid low and the operation discarded; flush has priority over in_valid and out_ready in that cycle.
REQ-025 in_valid with in_ready low SHALL have no effect; the upstream holds its inputs.

Reset
REQ-026 When rst_n is low at a rising clk edge, the FSM SHALL enter IDLE, and result, shift counter and captured operands SHALL clear to 0.
REQ-027 After reset, out_valid SHALL be 0, in_ready 1 and zero 1.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL discard the operation without producing out_valid.

Structure
REQ-029 The ALU operation codes SHALL be defined once in the shared package alu_pkg, used by both the ALU decoder and this block.
REQ-030 The FSM state enum SHALL be local to seq_alu.
REQ-031 Single-cycle ops SHALL be placed in one combinational sub-module alu_core; shift sequencing and FSM SHALL stay in seq_alu.

Verification
REQ-032 ADD: src_a=0xFFFFFFFF, src_b=1 -> out_valid one cycle after accept, result=0, zero=1.
REQ-033 SRA: src_a=0x80000000, src_b=4 -> out_valid 5 cycles after accept, result=0xF8000000; in_ready low throughout.
REQ-034 SLT vs SLTU: src_a=0xFFFFFFFF, src_b=1 -> SLT result=1; SLTU result=0, zero=1.
REQ-035 Back-pressure: out_ready held low 3 cycles in DONE -> result stable, in_ready low; out_ready high -> IDLE next cycle.
REQ-036 flush during SHIFT for SLL src_b=31 at cycle 10 -> IDLE next cycle, no out_valid, next op accepted normally.
REQ-037 rst_n low during DONE -> out_valid 0 and in_ready 1 after that edge; code 12 afterwards -> result 0 at latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// The operation codes live here once, so the ALU decoder and seq_alu always
// agree on the encoding. Also provides a small helper that classifies shifts.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    localparam int ALU_OP_W = 4;

    // Shifts are sequenced one bit per cycle by seq_alu; everything else
    // finishes in alu_core within a single cycle.
    function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU operations (combinational).
// Ports:
//   op : operation code (alu_pkg encoding)
//   a  : first operand
//   b  : second operand
//   y  : result; shift codes and undefined codes (10-15) give 0 here,
//        because shifts are produced by the sequencer in seq_alu.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic [XLEN-1:0]     y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete with latency 1; shifts move the
// working register by one bit per cycle (latency shamt+1, or 1 for shamt 0).
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      operation handshake (ready only in IDLE)
//   alu_control/src_a/b    operation code and operands
//   flush                  abandons any in-flight or pending operation
//   out_valid/out_ready    result handshake (valid only in DONE)
//   result, zero           result and its zero flag, held stable in DONE
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] alu_control,
    input  logic [XLEN-1:0]     src_a,
    input  logic [XLEN-1:0]     src_b,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                zero
);

    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [ALU_OP_W-1:0] op_q;
    logic [XLEN-1:0]     a_q, b_q;
    logic [XLEN-1:0]     res_q;
    logic [SW-1:0]       cnt_q;
    logic [XLEN-1:0]     core_y;
    logic [XLEN-1:0]     step;
    logic [SW-1:0]       shamt;
    logic                shift_op;
    logic                accept;

    alu_core #(.XLEN(XLEN)) u_core (
        .op (alu_control),
        .a  (src_a),
        .b  (src_b),
        .y  (core_y)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign zero      = (res_q == '0);

    assign shamt    = src_b[SW-1:0];
    assign shift_op = is_shift(alu_control);
    // flush wins over a simultaneous request
    assign accept   = in_valid && in_ready && !flush;

    // One shift step; SRA refills from the sign captured at accept.
    always_comb begin
        step = res_q;
        case (op_q)
            ALU_SLL: step = {res_q[XLEN-2:0], 1'b0};
            ALU_SRL: step = {1'b0, res_q[XLEN-1:1]};
            ALU_SRA: step = {a_q[XLEN-1], res_q[XLEN-1:1]};
            default: step = res_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (shift_op && shamt != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt_q == SW'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            op_q  <= alu_control;
            a_q   <= src_a;
            b_q   <= src_b;
            cnt_q <= shamt;
            // shifts start from src_a, which is also the shamt==0 answer
            res_q <= shift_op ? src_a : core_y;
        end else if (state_q == SHIFT && !flush) begin
            res_q <= step;
            cnt_q <= cnt_q - SW'(1);
        end
    end

    // Captured src_b and most of src_a are kept for visibility only; the
    // counter and working register already carry what the shifter needs.
    logic unused_ok;
    assign unused_ok = ^{a_q[XLEN-2:0], b_q};

endmodule
